// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Package : quad_pkg
// Brief   : Shared phase/state types and Gray-order helper for quad_decoder.
// Rev     : 1.0  initial release
// ============================================================================
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_01 = 2'b01;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_10 = 2'b10;

    // Successor of a phase in the up sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_t next_up(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage : quad_pkg
`default_nettype wire

// File: rtl/quad_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module  : quad_glitch_filter
// Brief   : Two-flop synchroniser plus persistence filter for one encoder phase.
// Rev     : 1.0  initial release
// ============================================================================
module quad_glitch_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q_filt,
    output logic q_valid
);

    localparam logic [3:0] LEN_M1 = 4'(FILTER_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [1:0] primed;
    logic [3:0] diff_cnt;
    logic [3:0] hold_cnt;

    // primed[1] marks sync2 as holding a genuine sample rather than its reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            primed   <= 2'b00;
            diff_cnt <= 4'd0;
            hold_cnt <= 4'd0;
            q_filt   <= 1'b0;
            q_valid  <= 1'b0;
        end else begin
            sync1  <= d_async;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            if (primed[1]) begin
                if (sync2 != q_filt) begin
                    hold_cnt <= 4'd0;
                    if (diff_cnt == LEN_M1) begin
                        q_filt   <= sync2;
                        diff_cnt <= 4'd0;
                        q_valid  <= 1'b1;
                    end else begin
                        diff_cnt <= diff_cnt + 4'd1;
                    end
                end else begin
                    diff_cnt <= 4'd0;
                    // A level that already matches the accepted one still has to
                    // persist for the full window before the channel counts as stable.
                    if (hold_cnt == LEN_M1) begin
                        q_valid <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule : quad_glitch_filter
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module  : quad_decoder
// Brief   : Quadrature decoder producing step/dir pulses, wrapping position and
//           a sticky illegal-transition flag.
// Rev     : 1.0  initial release
// ============================================================================
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr_err,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             err
);

    localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1);

    logic   a_filt;
    logic   b_filt;
    logic   a_valid;
    logic   b_valid;
    phase_t phase;
    phase_t ref_phase;
    state_t state;

    quad_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .d_async (a_in),
        .q_filt  (a_filt),
        .q_valid (a_valid)
    );

    quad_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .d_async (b_in),
        .q_filt  (b_filt),
        .q_valid (b_valid)
    );

    assign phase = {a_filt, b_filt};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            ref_phase <= PH_00;
            step      <= 1'b0;
            dir       <= 1'b1;
            position  <= '0;
            err       <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clr_err) begin
                err <= 1'b0;
            end
            case (state)
                INIT: begin
                    if (a_valid && b_valid) begin
                        ref_phase <= phase;
                        state     <= TRACK;
                    end
                end
                TRACK: begin
                    if (phase != ref_phase) begin
                        ref_phase <= phase;
                        if (phase == next_up(ref_phase)) begin
                            step     <= 1'b1;
                            dir      <= 1'b1;
                            position <= position + POS_ONE;
                        end else if (ref_phase == next_up(phase)) begin
                            step     <= 1'b1;
                            dir      <= 1'b0;
                            position <= position - POS_ONE;
                        end else begin
                            // Both bits moved together; placed after clr_err so set wins.
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule : quad_decoder
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad_decoder
// Brief   : Self-checking bench for quad_decoder against a Gray-index model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int FL  = 3;
    localparam int W   = 8;
    localparam int LAT = FL + 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_in = 1'b0;
    logic         b_in = 1'b0;
    logic         clr_err = 1'b0;
    logic         step;
    logic         dir;
    logic [W-1:0] position;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [1:0] cur = 2'b00;
    int         m_pos = 0;
    logic       m_dir = 1'b1;
    logic       m_err = 1'b0;

    quad_decoder #(
        .FILTER_LEN (FL),
        .WIDTH      (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_in     (a_in),
        .b_in     (b_in),
        .clr_err  (clr_err),
        .step     (step),
        .dir      (dir),
        .position (position),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Position of a phase in the up cycle 00,01,11,10.
    function automatic int gidx(input logic [1:0] ph);
        case (ph)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gphase(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic check_outputs(input logic exp_step);
        check("step", 32'(step), 32'(exp_step));
        check("err", 32'(err), 32'(m_err));
        check("position", 32'(position), 32'(m_pos));
        check("dir", 32'(dir), 32'(m_dir));
    endtask

    task automatic do_reset(input logic [1:0] ph);
        a_in    = ph[1];
        b_in    = ph[0];
        clr_err = 1'b0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_pos = 0; m_dir = 1'b1; m_err = 1'b0;
        check_outputs(1'b0);
        check("state_init", 32'(dut.state), 32'(INIT));
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs(1'b0);
        end
        check("state_track", 32'(dut.state), 32'(TRACK));
        check("ref_phase", 32'(dut.ref_phase), 32'(ph));
        cur = ph;
    endtask

    // Drive a new phase, hold it, and check every cycle; clr_err is sampled on edge clr_at.
    task automatic move(input logic [1:0] np, input int hold, input int clr_at);
        int d;
        d    = (gidx(np) - gidx(cur) + 4) % 4;
        a_in = np[1];
        b_in = np[0];
        for (int k = 1; k <= hold; k++) begin
            clr_err = (k == clr_at);
            @(posedge clk);
            if (k == clr_at) m_err = 1'b0;
            if (k == LAT) begin
                if (d == 1) begin m_pos = (m_pos + 1) % (1 << W); m_dir = 1'b1; end
                if (d == 3) begin m_pos = (m_pos + (1 << W) - 1) % (1 << W); m_dir = 1'b0; end
                if (d == 2) m_err = 1'b1;
            end
            @(negedge clk);
            check_outputs(k == LAT && (d == 1 || d == 3));
        end
        clr_err = 1'b0;
        cur = np;
    endtask

    // Pulse phase A away from its current level for pw cycles and return.
    task automatic pulse_a(input int pw);
        logic pass;
        int   d_up;
        pass = (pw >= FL);
        d_up = (gidx({~cur[1], cur[0]}) - gidx(cur) + 4) % 4;
        a_in = ~cur[1];
        for (int k = 1; k <= pw + LAT + 4; k++) begin
            if (k == pw + 1) a_in = cur[1];
            @(posedge clk);
            if (pass && k == LAT) begin
                m_pos = (d_up == 1) ? (m_pos + 1) % (1 << W) : (m_pos + (1 << W) - 1) % (1 << W);
                m_dir = (d_up == 1);
            end
            if (pass && k == pw + LAT) begin
                m_pos = (d_up == 1) ? (m_pos + (1 << W) - 1) % (1 << W) : (m_pos + 1) % (1 << W);
                m_dir = (d_up != 1);
            end
            @(negedge clk);
            check_outputs(pass && (k == LAT || k == pw + LAT));
        end
    endtask

    initial begin
        int r;
        int d;

        // Reset with both phases high; INIT must settle on 11 without stepping.
        @(negedge clk);
        do_reset(2'b11);

        // Up count through a full wrap of the 8-bit position.
        do_reset(2'b00);
        for (int s = 1; s <= 256; s++) begin
            move(next_up(cur), 8, 0);
            if (s == 255) check("pos_255", 32'(position), 32'd255);
            if (s == 256) check("pos_wrap", 32'(position), 32'd0);
        end

        // Down count with underflow.
        do_reset(2'b00);
        move(2'b10, 8, 0);
        check("pos_underflow", 32'(position), 32'd255);
        move(2'b11, 8, 0);
        check("pos_254", 32'(position), 32'd254);

        // Glitch rejection from phase 01 (A low).
        move(2'b01, 8, 0);
        pulse_a(2);
        pulse_a(3);

        // Illegal transitions and err clearing.
        do_reset(2'b00);
        move(2'b11, 8, 0);
        check("err_set", 32'(err), 32'd1);
        move(2'b00, 8, LAT);
        check("err_set_wins", 32'(err), 32'd1);
        move(2'b00, 4, 1);
        check("err_cleared", 32'(err), 32'd0);

        // Randomised walk mixing legal steps and occasional illegal jumps.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            d = (r == 0) ? 2 : ((r < 5) ? 1 : 3);
            move(gphase(gidx(cur) + d), int'($urandom_range(6, 12)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0);
        end

        // Reset in the middle of a filtered edge.
        do_reset(2'b00);
        for (int s = 0; s < 37; s++) move(next_up(cur), int'($urandom_range(6, 10)), 0);
        check("pos_37", 32'(position), 32'd37);
        a_in = ~cur[1];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("step_pre_reset", 32'(step), 32'd0);
        end
        do_reset({a_in, b_in});
        move(next_up(cur), 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_quad_decoder
`default_nettype wire
